// File: rtl/ccu_wr_pkg.sv
// Shared ACE write-channel types for the CCU write dispatcher.
// Only the fields the dispatcher and its neighbours touch are modelled.
package ccu_wr_pkg;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  domain;
        logic [2:0]  snoop;
    } aw_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_t;

    typedef struct packed {
        aw_t  aw;
        logic aw_valid;
        w_t   w;
        logic w_valid;
        logic b_ready;
        ar_t  ar;
        logic ar_valid;
        logic r_ready;
        logic wack;
        logic rack;
    } ace_req_t;

    typedef struct packed {
        logic aw_ready;
        logic ar_ready;
        logic w_ready;
        logic b_valid;
        b_t   b;
        logic r_valid;
        r_t   r;
    } ace_resp_t;

    typedef enum logic [1:0] {
        IDLE,
        SNP,
        BYP
    } state_e;

endpackage

// File: rtl/ccu_wr_dispatch.sv
// Splits cached-master writes into a snooping path and a memory bypass path.
// Define CCU_WR_DISPATCH_EVICT_ABSORB_EN to absorb shareable Evicts locally.
module ccu_wr_dispatch
    import ccu_wr_pkg::*;
#(
    parameter type         slv_req_t  = ace_req_t,
    parameter type         slv_resp_t = ace_resp_t,
    parameter int unsigned MaxTrans   = 4
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  slv_req_t  slv_req_i,
    output slv_resp_t slv_resp_o,
    output slv_req_t  snp_req_o,
    input  slv_resp_t snp_resp_i,
    output logic [3:0] snoop_trs_o,
    output slv_req_t  mem_req_o,
    input  slv_resp_t mem_resp_i
);

    localparam int unsigned     CntW   = $clog2(MaxTrans + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxTrans);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    state_e          state;
    state_e          state_next;
    logic [CntW-1:0] out_cnt;
    logic [CntW-1:0] out_cnt_next;
    logic [CntW-1:0] w_cnt;
    logic [CntW-1:0] w_cnt_next;

    logic       shareable;
    logic       is_snp;
    logic       is_byp;
    logic [3:0] trs;
    logic       aw_hold;
    logic       byp_aw_ok;
    logic       mem_aw_hs;
    logic       w_en;
    logic       w_last_hs;
    logic       mem_b_hs;

    assign shareable = (slv_req_i.aw.domain == 2'b01) ||
                       (slv_req_i.aw.domain == 2'b10);
    assign is_snp = shareable && ((slv_req_i.aw.snoop == 3'b000) ||
                                  (slv_req_i.aw.snoop == 3'b001));

    always_comb begin
        trs = 4'b0000;
        if (slv_req_i.aw.snoop == 3'b000) begin
            trs = 4'b1001;
        end else if (slv_req_i.aw.snoop == 3'b001) begin
            trs = 4'b1101;
        end
    end

`ifdef CCU_WR_DISPATCH_EVICT_ABSORB_EN
    logic                               is_evict;
    logic                               evict_set;
    logic                               evict_b_q;
    logic [$bits(slv_req_i.aw.id)-1:0]  evict_id_q;

    assign is_evict  = shareable && (slv_req_i.aw.snoop == 3'b100);
    assign is_byp    = !is_snp && !is_evict;
    assign aw_hold   = evict_b_q;
    assign evict_set = (state == IDLE) && !evict_b_q &&
                       slv_req_i.aw_valid && is_evict;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            evict_b_q  <= 1'b0;
            evict_id_q <= '0;
        end else if (evict_set) begin
            evict_b_q  <= 1'b1;
            evict_id_q <= slv_req_i.aw.id;
        end else if (evict_b_q && slv_req_i.b_ready) begin
            evict_b_q  <= 1'b0;
        end
    end
`else
    assign is_byp  = !is_snp;
    assign aw_hold = 1'b0;
`endif

    assign byp_aw_ok = slv_req_i.aw_valid && is_byp && !aw_hold &&
                       ((state == IDLE) ||
                        ((state == BYP) && (out_cnt < CntMax)));
    assign mem_aw_hs = byp_aw_ok && mem_resp_i.aw_ready;
    // An AW accepted this very cycle already owns the W beat on the bus.
    assign w_en      = (state != SNP) && ((w_cnt != '0) || mem_aw_hs);
    assign w_last_hs = w_en && slv_req_i.w_valid &&
                       mem_resp_i.w_ready && slv_req_i.w.last;
    assign mem_b_hs  = (state != SNP) && (out_cnt != '0) &&
                       mem_resp_i.b_valid && slv_req_i.b_ready;

    always_comb begin
        out_cnt_next = out_cnt;
        if (mem_aw_hs && !mem_b_hs) begin
            out_cnt_next = out_cnt + CntOne;
        end else if (!mem_aw_hs && mem_b_hs) begin
            out_cnt_next = out_cnt - CntOne;
        end
        w_cnt_next = w_cnt;
        if (mem_aw_hs && !w_last_hs) begin
            w_cnt_next = w_cnt + CntOne;
        end else if (!mem_aw_hs && w_last_hs) begin
            w_cnt_next = w_cnt - CntOne;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            out_cnt <= '0;
            w_cnt   <= '0;
        end else begin
            state   <= state_next;
            out_cnt <= out_cnt_next;
            w_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        slv_resp_o   = '0;
        snp_req_o    = '0;
        mem_req_o    = '0;
        snoop_trs_o  = 4'b0000;
        state_next   = state;
        snp_req_o.aw = slv_req_i.aw;
        snp_req_o.w  = slv_req_i.w;
        mem_req_o.aw = slv_req_i.aw;
        mem_req_o.w  = slv_req_i.w;

        unique case (state)
            IDLE: begin
                if (!aw_hold && slv_req_i.aw_valid && is_snp) begin
                    snp_req_o.aw_valid  = 1'b1;
                    slv_resp_o.aw_ready = snp_resp_i.aw_ready;
                    snoop_trs_o         = trs;
                    if (snp_resp_i.aw_ready) begin
                        state_next = SNP;
                    end
                end else if (byp_aw_ok) begin
                    mem_req_o.aw_valid  = 1'b1;
                    slv_resp_o.aw_ready = mem_resp_i.aw_ready;
                    if (mem_resp_i.aw_ready) begin
                        state_next = BYP;
                    end
                end
`ifdef CCU_WR_DISPATCH_EVICT_ABSORB_EN
                else if (evict_set) begin
                    slv_resp_o.aw_ready = 1'b1;
                end
`endif
            end
            SNP: begin
                snp_req_o.w_valid  = slv_req_i.w_valid;
                slv_resp_o.w_ready = snp_resp_i.w_ready;
                slv_resp_o.b_valid = snp_resp_i.b_valid;
                slv_resp_o.b       = snp_resp_i.b;
                snp_req_o.b_ready  = slv_req_i.b_ready;
                if (snp_resp_i.b_valid && slv_req_i.b_ready) begin
                    state_next = IDLE;
                end
            end
            BYP: begin
                if (byp_aw_ok) begin
                    mem_req_o.aw_valid  = 1'b1;
                    slv_resp_o.aw_ready = mem_resp_i.aw_ready;
                end
                if (out_cnt_next == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (state != SNP) begin
            mem_req_o.w_valid  = slv_req_i.w_valid && w_en;
            slv_resp_o.w_ready = mem_resp_i.w_ready && w_en;
            if (out_cnt != '0) begin
                slv_resp_o.b_valid = mem_resp_i.b_valid;
                slv_resp_o.b       = mem_resp_i.b;
                mem_req_o.b_ready  = slv_req_i.b_ready;
            end
        end

`ifdef CCU_WR_DISPATCH_EVICT_ABSORB_EN
        if (evict_b_q) begin
            slv_resp_o.b_valid = 1'b1;
            slv_resp_o.b       = '0;
            slv_resp_o.b.id    = evict_id_q;
        end
`endif

        if (!rst_ni) begin
            slv_resp_o  = '0;
            snp_req_o   = '0;
            mem_req_o   = '0;
            snoop_trs_o = 4'b0000;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{slv_req_i.ar, slv_req_i.ar_valid, slv_req_i.r_ready,
                         slv_req_i.wack, slv_req_i.rack,
                         snp_resp_i.ar_ready, snp_resp_i.r_valid, snp_resp_i.r,
                         mem_resp_i.ar_ready, mem_resp_i.r_valid, mem_resp_i.r};

endmodule

// File: tb/tb_ccu_wr_dispatch.sv
// Directed self-checking bench for ccu_wr_dispatch.
// Build with CCU_WR_DISPATCH_EVICT_ABSORB_EN to exercise Evict absorption.
module tb_ccu_wr_dispatch;
    import ccu_wr_pkg::*;

    logic      clk;
    logic      rst_n;
    ace_req_t  slv_req;
    ace_resp_t slv_resp;
    ace_req_t  snp_req;
    ace_resp_t snp_resp;
    logic [3:0] trs;
    ace_req_t  mem_req;
    ace_resp_t mem_resp;

    int checks;
    int errors;

    ccu_wr_dispatch #(
        .slv_req_t  (ace_req_t),
        .slv_resp_t (ace_resp_t),
        .MaxTrans   (4)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .slv_req_i   (slv_req),
        .slv_resp_o  (slv_resp),
        .snp_req_o   (snp_req),
        .snp_resp_i  (snp_resp),
        .snoop_trs_o (trs),
        .mem_req_o   (mem_req),
        .mem_resp_i  (mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_aw(input logic [3:0] id, input logic [1:0] dom,
                          input logic [2:0] snp, input logic [7:0] len);
        slv_req.aw.id     = id;
        slv_req.aw.addr   = 32'h1000;
        slv_req.aw.len    = len;
        slv_req.aw.domain = dom;
        slv_req.aw.snoop  = snp;
    endtask

    task automatic test_reset();
        slv_req = '0;
        snp_resp = '0;
        mem_resp = '0;
        rst_n = 1'b0;
        #1;
        set_aw(4'd1, 2'b01, 3'b000, 8'd0);
        slv_req.aw_valid = 1'b1;
        slv_req.w_valid = 1'b1;
        slv_req.b_ready = 1'b1;
        snp_resp.aw_ready = 1'b1;
        mem_resp.aw_ready = 1'b1;
        mem_resp.w_ready = 1'b1;
        tick();
        checks++;
        if (slv_resp.aw_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_aw_ready got %b want 0", slv_resp.aw_ready);
        end
        checks++;
        if (snp_req.aw_valid !== 1'b0 || mem_req.aw_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_aw_valid got snp=%b mem=%b want 0",
                     snp_req.aw_valid, mem_req.aw_valid);
        end
        checks++;
        if (slv_resp.w_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_w_ready got %b want 0", slv_resp.w_ready);
        end
        checks++;
        if (dut.state !== IDLE || dut.out_cnt !== 3'd0 || dut.w_cnt !== 3'd0) begin
            errors++;
            $display("FAIL rst_state got st=%0d out=%0d w=%0d want 0 0 0",
                     dut.state, dut.out_cnt, dut.w_cnt);
        end
        slv_req.aw_valid = 1'b0;
        slv_req.w_valid = 1'b0;
        snp_resp.w_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_unique();
        int beats;
        set_aw(4'd3, 2'b01, 3'b000, 8'd3);
        slv_req.aw_valid = 1'b1;
        #1;
        checks++;
        if (snp_req.aw_valid !== 1'b1 || trs !== 4'b1001) begin
            errors++;
            $display("FAIL wu_aw got valid=%b trs=%b want 1 1001",
                     snp_req.aw_valid, trs);
        end
        checks++;
        if (slv_resp.aw_ready !== 1'b1 || mem_req.aw_valid !== 1'b0) begin
            errors++;
            $display("FAIL wu_route got rdy=%b mem_valid=%b want 1 0",
                     slv_resp.aw_ready, mem_req.aw_valid);
        end
        tick();
        slv_req.aw_valid = 1'b0;
        checks++;
        if (dut.state !== SNP) begin
            errors++;
            $display("FAIL wu_state got %0d want SNP", dut.state);
        end
        beats = 0;
        for (int i = 0; i < 4; i++) begin
            slv_req.w.data = 32'(i + 16);
            slv_req.w.last = (i == 3);
            slv_req.w_valid = 1'b1;
            #1;
            if (snp_req.w_valid && slv_resp.w_ready && !mem_req.w_valid &&
                snp_req.w.data == 32'(i + 16)) begin
                beats++;
            end
            tick();
        end
        slv_req.w_valid = 1'b0;
        checks++;
        if (beats !== 4) begin
            errors++;
            $display("FAIL wu_beats got %0d want 4", beats);
        end
        snp_resp.b_valid = 1'b1;
        snp_resp.b.id = 4'd3;
        snp_resp.b.resp = 2'b00;
        #1;
        checks++;
        if (slv_resp.b_valid !== 1'b1 || slv_resp.b.id !== 4'd3 ||
            snp_req.b_ready !== 1'b1) begin
            errors++;
            $display("FAIL wu_b got v=%b id=%0d rdy=%b want 1 3 1",
                     slv_resp.b_valid, slv_resp.b.id, snp_req.b_ready);
        end
        tick();
        snp_resp.b_valid = 1'b0;
        checks++;
        if (dut.state !== IDLE) begin
            errors++;
            $display("FAIL wu_idle got %0d want IDLE", dut.state);
        end
    endtask

    task automatic test_back_to_back();
        set_aw(4'd7, 2'b00, 3'b011, 8'd0);
        slv_req.aw_valid = 1'b1;
        slv_req.w_valid = 1'b1;
        slv_req.w.last = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            #1;
            checks++;
            if (slv_resp.aw_ready !== 1'b1 || slv_resp.w_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_accept_%0d got aw=%b w=%b want 1 1",
                         k, slv_resp.aw_ready, slv_resp.w_ready);
            end
            tick();
            checks++;
            if (dut.out_cnt !== 3'(k)) begin
                errors++;
                $display("FAIL b2b_cnt_%0d got %0d want %0d", k, dut.out_cnt, k);
            end
        end
        #1;
        checks++;
        if (slv_resp.aw_ready !== 1'b0 || mem_req.aw_valid !== 1'b0 ||
            slv_resp.w_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stall got aw=%b mv=%b w=%b want 0 0 0",
                     slv_resp.aw_ready, mem_req.aw_valid, slv_resp.w_ready);
        end
        mem_resp.b_valid = 1'b1;
        mem_resp.b.id = 4'd7;
        #1;
        checks++;
        if (slv_resp.aw_ready !== 1'b0 || slv_resp.b_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_b got aw=%b b=%b want 0 1",
                     slv_resp.aw_ready, slv_resp.b_valid);
        end
        tick();
        mem_resp.b_valid = 1'b0;
        checks++;
        if (dut.out_cnt !== 3'd3) begin
            errors++;
            $display("FAIL b2b_cnt_after_b got %0d want 3", dut.out_cnt);
        end
        #1;
        checks++;
        if (slv_resp.aw_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_fifth got %b want 1", slv_resp.aw_ready);
        end
        tick();
        slv_req.aw_valid = 1'b0;
        slv_req.w_valid = 1'b0;
        mem_resp.b_valid = 1'b1;
        repeat (4) tick();
        mem_resp.b_valid = 1'b0;
        checks++;
        if (dut.out_cnt !== 3'd0 || dut.w_cnt !== 3'd0 || dut.state !== IDLE) begin
            errors++;
            $display("FAIL b2b_drain got out=%0d w=%0d st=%0d want 0 0 IDLE",
                     dut.out_cnt, dut.w_cnt, dut.state);
        end
    endtask

    task automatic test_w_before_aw();
        set_aw(4'd2, 2'b00, 3'b000, 8'd1);
        slv_req.w_valid = 1'b1;
        slv_req.w.data = 32'hAA;
        slv_req.w.last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (slv_resp.w_ready !== 1'b0 || mem_req.w_valid !== 1'b0) begin
                errors++;
                $display("FAIL wfirst_hold_%0d got rdy=%b mv=%b want 0 0",
                         i, slv_resp.w_ready, mem_req.w_valid);
            end
            tick();
        end
        slv_req.aw_valid = 1'b1;
        #1;
        checks++;
        if (slv_resp.aw_ready !== 1'b1 || slv_resp.w_ready !== 1'b1 ||
            mem_req.w_valid !== 1'b1) begin
            errors++;
            $display("FAIL wfirst_fwd got aw=%b w=%b mv=%b want 1 1 1",
                     slv_resp.aw_ready, slv_resp.w_ready, mem_req.w_valid);
        end
        tick();
        slv_req.aw_valid = 1'b0;
        slv_req.w.data = 32'hBB;
        slv_req.w.last = 1'b1;
        #1;
        checks++;
        if (slv_resp.w_ready !== 1'b1 || mem_req.w.data !== 32'hBB) begin
            errors++;
            $display("FAIL wfirst_beat2 got rdy=%b data=%h want 1 bb",
                     slv_resp.w_ready, mem_req.w.data);
        end
        tick();
        slv_req.w_valid = 1'b0;
        checks++;
        if (dut.w_cnt !== 3'd0 || dut.out_cnt !== 3'd1) begin
            errors++;
            $display("FAIL wfirst_cnt got w=%0d out=%0d want 0 1",
                     dut.w_cnt, dut.out_cnt);
        end
        mem_resp.b_valid = 1'b1;
        tick();
        mem_resp.b_valid = 1'b0;
    endtask

    task automatic test_snoop_after_bypass();
        set_aw(4'd4, 2'b00, 3'b011, 8'd0);
        slv_req.aw_valid = 1'b1;
        slv_req.w_valid = 1'b1;
        slv_req.w.last = 1'b1;
        tick();
        tick();
        slv_req.aw_valid = 1'b0;
        slv_req.w_valid = 1'b0;
        checks++;
        if (dut.out_cnt !== 3'd2) begin
            errors++;
            $display("FAIL wlu_setup got %0d want 2", dut.out_cnt);
        end
        set_aw(4'd6, 2'b10, 3'b001, 8'd0);
        slv_req.aw_valid = 1'b1;
        #1;
        checks++;
        if (slv_resp.aw_ready !== 1'b0 || snp_req.aw_valid !== 1'b0) begin
            errors++;
            $display("FAIL wlu_stall got rdy=%b sv=%b want 0 0",
                     slv_resp.aw_ready, snp_req.aw_valid);
        end
        mem_resp.b_valid = 1'b1;
        tick();
        checks++;
        if (snp_req.aw_valid !== 1'b0) begin
            errors++;
            $display("FAIL wlu_stall_one_b got %b want 0", snp_req.aw_valid);
        end
        tick();
        mem_resp.b_valid = 1'b0;
        #1;
        checks++;
        if (snp_req.aw_valid !== 1'b1 || trs !== 4'b1101 ||
            slv_resp.aw_ready !== 1'b1) begin
            errors++;
            $display("FAIL wlu_go got v=%b trs=%b rdy=%b want 1 1101 1",
                     snp_req.aw_valid, trs, slv_resp.aw_ready);
        end
        tick();
        slv_req.aw_valid = 1'b0;
        slv_req.w_valid = 1'b1;
        tick();
        slv_req.w_valid = 1'b0;
        snp_resp.b_valid = 1'b1;
        snp_resp.b.id = 4'd6;
        tick();
        snp_resp.b_valid = 1'b0;
        checks++;
        if (dut.state !== IDLE) begin
            errors++;
            $display("FAIL wlu_idle got %0d want IDLE", dut.state);
        end
    endtask

    task automatic test_evict();
        set_aw(4'd5, 2'b01, 3'b100, 8'd0);
        slv_req.aw_valid = 1'b1;
`ifdef CCU_WR_DISPATCH_EVICT_ABSORB_EN
        slv_req.b_ready = 1'b0;
        #1;
        checks++;
        if (slv_resp.aw_ready !== 1'b1 || mem_req.aw_valid !== 1'b0 ||
            snp_req.aw_valid !== 1'b0 || slv_resp.b_valid !== 1'b0) begin
            errors++;
            $display("FAIL ev_accept got rdy=%b mv=%b sv=%b b=%b want 1 0 0 0",
                     slv_resp.aw_ready, mem_req.aw_valid,
                     snp_req.aw_valid, slv_resp.b_valid);
        end
        tick();
        set_aw(4'd9, 2'b00, 3'b011, 8'd0);
        #1;
        checks++;
        if (slv_resp.b_valid !== 1'b1 || slv_resp.b.id !== 4'd5 ||
            slv_resp.b.resp !== 2'b00) begin
            errors++;
            $display("FAIL ev_b got v=%b id=%0d resp=%b want 1 5 00",
                     slv_resp.b_valid, slv_resp.b.id, slv_resp.b.resp);
        end
        checks++;
        if (slv_resp.aw_ready !== 1'b0 || mem_req.aw_valid !== 1'b0) begin
            errors++;
            $display("FAIL ev_aw_stall got rdy=%b mv=%b want 0 0",
                     slv_resp.aw_ready, mem_req.aw_valid);
        end
        tick();
        checks++;
        if (slv_resp.b_valid !== 1'b1) begin
            errors++;
            $display("FAIL ev_b_hold got %b want 1", slv_resp.b_valid);
        end
        slv_req.b_ready = 1'b1;
        tick();
        checks++;
        if (slv_resp.b_valid !== 1'b0 || slv_resp.aw_ready !== 1'b1) begin
            errors++;
            $display("FAIL ev_b_done got b=%b rdy=%b want 0 1",
                     slv_resp.b_valid, slv_resp.aw_ready);
        end
        slv_req.w_valid = 1'b1;
        slv_req.w.last = 1'b1;
        tick();
        slv_req.aw_valid = 1'b0;
        slv_req.w_valid = 1'b0;
        mem_resp.b_valid = 1'b1;
        tick();
        mem_resp.b_valid = 1'b0;
`else
        slv_req.w_valid = 1'b1;
        slv_req.w.last = 1'b1;
        #1;
        checks++;
        if (mem_req.aw_valid !== 1'b1 || snp_req.aw_valid !== 1'b0 ||
            slv_resp.aw_ready !== 1'b1) begin
            errors++;
            $display("FAIL ev_bypass got mv=%b sv=%b rdy=%b want 1 0 1",
                     mem_req.aw_valid, snp_req.aw_valid, slv_resp.aw_ready);
        end
        tick();
        slv_req.aw_valid = 1'b0;
        slv_req.w_valid = 1'b0;
        mem_resp.b_valid = 1'b1;
        mem_resp.b.id = 4'd5;
        #1;
        checks++;
        if (slv_resp.b_valid !== 1'b1 || slv_resp.b.id !== 4'd5) begin
            errors++;
            $display("FAIL ev_b got v=%b id=%0d want 1 5",
                     slv_resp.b_valid, slv_resp.b.id);
        end
        tick();
        mem_resp.b_valid = 1'b0;
`endif
        checks++;
        if (dut.state !== IDLE || dut.out_cnt !== 3'd0) begin
            errors++;
            $display("FAIL ev_idle got st=%0d out=%0d want IDLE 0",
                     dut.state, dut.out_cnt);
        end
    endtask

    task automatic test_reset_mid_burst();
        set_aw(4'd8, 2'b00, 3'b011, 8'd3);
        slv_req.aw_valid = 1'b1;
        slv_req.w_valid = 1'b1;
        slv_req.w.last = 1'b0;
        tick();
        slv_req.aw_valid = 1'b0;
        slv_req.w.data = 32'h2;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dut.out_cnt !== 3'd0 || dut.w_cnt !== 3'd0 || dut.state !== IDLE) begin
            errors++;
            $display("FAIL mid_rst_state got out=%0d w=%0d st=%0d want 0 0 IDLE",
                     dut.out_cnt, dut.w_cnt, dut.state);
        end
        mem_resp.b_valid = 1'b1;
        #1;
        checks++;
        if (slv_resp.b_valid !== 1'b0 || slv_resp.w_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_out got b=%b w=%b want 0 0",
                     slv_resp.b_valid, slv_resp.w_ready);
        end
        tick();
        rst_n = 1'b1;
        slv_req.w_valid = 1'b0;
        #1;
        checks++;
        if (slv_resp.b_valid !== 1'b0 || mem_req.b_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_orphan_b got b=%b rdy=%b want 0 0",
                     slv_resp.b_valid, mem_req.b_ready);
        end
        mem_resp.b_valid = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_write_unique();
        test_back_to_back();
        test_w_before_aw();
        test_snoop_after_bypass();
        test_evict();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ccu_wr_dispatch.md
CCU_WR_DISPATCH -- requirements
Module: ccu_wr_dispatch

Interface
REQ-001 Parameter slv_req_t, default logic: ACE request type from the cached master, also used on both downstream ports.
REQ-002 Parameter slv_resp_t, default logic: ACE response type matching slv_req_t.
REQ-003 Parameter MaxTrans, default 4: maximum outstanding bypass writes, ≥1.
REQ-004 clk_i  input  1  clock; single clock domain.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 slv_req_i  input  slv_req_t  write request from the cached master; only the AW, W and B fields are used.
REQ-007 slv_resp_o  output  slv_resp_t  write response to the cached master.
REQ-008 snp_req_o  output  slv_req_t  snooping-write path to the write-snoop FSM.
REQ-009 snp_resp_i  input  slv_resp_t  response from the write-snoop FSM.
REQ-010 snoop_trs_o  output  4  decoded AC snoop code, valid while snp_req_o.aw_valid is high.
REQ-011 mem_req_o  output  slv_req_t  bypass write path towards memory.
REQ-012 mem_resp_i  input  slv_resp_t  bypass response from memory.

Function
REQ-013 The block SHALL classify the AW as snooping when the AW domain is InnerShareable or OuterShareable and awsnoop is 3'b000 (WriteUnique) or 3'b001 (WriteLineUnique); every other AW is bypass.
REQ-014 Decode SHALL be combinational: WriteUnique→CleanInvalid (4'b1001), WriteLineUnique→MakeInvalid (4'b1101), all others→4'b0000.
REQ-015 The FSM SHALL have three states: IDLE, SNP and BYP.
REQ-016 IDLE: a snooping AW SHALL be passed through as valid/ready to snp_req_o, moving to SNP on the handshake; a bypass AW SHALL be passed to mem_req_o, moving to BYP on the handshake.
REQ-017 SNP: W from the master SHALL pass through to snp_req_o, and B/b_ready SHALL pass through from snp_resp_i.
REQ-018 SNP: all new AWs SHALL be stalled (aw_ready=0).
REQ-019 SNP SHALL return to IDLE on the cycle after the slave-side B handshake.
REQ-020 BYP: further bypass AWs SHALL be accepted while out_cnt<MaxTrans.
REQ-021 BYP: snooping AWs SHALL stall until out_cnt=0; the FSM SHALL then return to IDLE.
REQ-022 out_cnt SHALL increment on a bypass AW handshake and decrement on a mem B handshake; a simultaneous increment and decrement SHALL leave it unchanged.
REQ-023 w_cnt (bursts whose AW is accepted and W last is not yet sent) SHALL increment on a bypass AW handshake and decrement on a W last handshake; simultaneous events SHALL net to zero.
REQ-024 In BYP, W SHALL be forwarded to memory only while w_cnt>0; otherwise slv w_ready=0 and no W beat is dropped or reordered.
REQ-025 A same-cycle AW handshake SHALL enable W forwarding that cycle.
REQ-026 All ready/valid paths SHALL be combinational pass-through with zero added latency.
REQ-027 No valid SHALL be retracted before its handshake.
REQ-028 Unused AR/R/ACK outputs SHALL be driven to zero; AR/R inputs SHALL be ignored.
REQ-029 Both counters SHALL be $clog2(MaxTrans+1) bits wide and SHALL never wrap.
REQ-030 W or B arriving with no owning transaction SHALL be held off with ready=0.
REQ-031 Only one path SHALL have aw_valid asserted in any cycle.

Reset
REQ-032 Asserting rst_ni low SHALL immediately force state=IDLE, out_cnt=0, w_cnt=0 and evict_b_q=0; all valid and ready outputs SHALL be 0 during reset.
REQ-033 A reset mid-burst SHALL abandon in-flight transactions without generating any B.

Configuration
REQ-034 Macro CCU_WR_DISPATCH_EVICT_ABSORB_EN defined: a shareable Evict (awsnoop 3'b100) in IDLE SHALL be accepted locally (aw_ready=1) and not forwarded.
REQ-035 With the macro defined, the absorbed Evict SHALL set evict_b_q, which drives slv b_valid with resp=OKAY and the AW id one cycle later; the B SHALL be held until b_ready; AWs SHALL stall meanwhile.
REQ-036 Macro undefined: Evict SHALL be handled as a bypass write, and evict_b_q logic SHALL be absent.

Verification
REQ-037 WriteUnique, domain InnerShareable, 4 beats → snp aw_valid=1, snoop_trs_o=4'b1001, all 4 W beats on snp_req_o, B passed through, state back to IDLE.
REQ-038 Four WriteBack AWs back-to-back, MaxTrans=4 → all accepted, fifth AW stalled until the first mem B, out_cnt sequence 1,2,3,4,3.
REQ-039 W beats presented 3 cycles before a WriteNoSnoop AW → w_ready=0 for 3 cycles; beats forwarded in the AW handshake cycle.
REQ-040 WriteLineUnique issued while 2 bypass writes are outstanding → stalled until both B received, then snoop_trs_o=4'b1101.
REQ-041 Macro on, Evict id=5 → B id=5, resp=OKAY one cycle later; mem and snp aw_valid stay 0.
REQ-042 rst_ni low during beat 2 of a bypass burst → counters 0, state IDLE, no slave B issued.
